// File: rtl/camera_config_pkg.sv
// Shared types and the default D5M register table for the camera configuration sequencer.
package camera_config_pkg;

    localparam int unsigned NUM_REGS         = 25;
    localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'hBA;

    typedef struct packed {
        logic [7:0]  reg_addr;
        logic [15:0] data;
    } entry_t;

    typedef entry_t [31:0] table_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSendBit,
        StAck,
        StStop,
        StGap,
        StFinish
    } state_e;

    function automatic table_t d5m_table();
        table_t t;
        t     = '0;
        t[0]  = 24'h000000;
        t[1]  = 24'h20C000;  // mirror rows and columns
        t[2]  = 24'h090797;  // exposure
        t[3]  = 24'h050000;
        t[4]  = 24'h060019;
        t[5]  = 24'h0A8000;
        t[6]  = 24'h2B0013;
        t[7]  = 24'h2C009A;
        t[8]  = 24'h2D019C;
        t[9]  = 24'h2E0013;
        t[10] = 24'h100051;  // PLL power-up before switching the clock over
        t[11] = 24'h111807;
        t[12] = 24'h120002;
        t[13] = 24'h100053;
        t[14] = 24'h980000;
        t[15] = 24'hA00000;
        t[16] = 24'hA10000;
        t[17] = 24'hA20FFF;
        t[18] = 24'h010036;
        t[19] = 24'h020010;
        t[20] = 24'h03077F;
        t[21] = 24'h040A1F;
        t[22] = 24'h220000;
        t[23] = 24'h230000;
        t[24] = 24'h4901A8;
        return t;
    endfunction

    localparam table_t D5M_TABLE = d5m_table();

endpackage

// File: rtl/camera_config_rom.sv
// Combinational lookup of one register-table entry by index.
module camera_config_rom
    import camera_config_pkg::*;
#(
    parameter table_t REG_TABLE = D5M_TABLE
) (
    input  logic [4:0]  index,
    output logic [23:0] entry
);

    assign entry = REG_TABLE[index];

endmodule

// File: rtl/camera_config_seq.sv
// I2C write sequencer: streams a register table to the camera, one START..STOP per entry,
// reporting completion or the index of the first NACKed entry.
module camera_config_seq
    import camera_config_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 125,
    parameter bit          AUTO_START  = 1'b1,
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int unsigned NUM_ENTRIES = NUM_REGS,
    parameter table_t      REG_TABLE   = D5M_TABLE
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       start,
    output logic       camera_config_SCLK,
    inout  wire        camera_config_SDAT,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [4:0] err_index
);

    localparam logic [9:0] DivLast = 10'(CLK_DIV - 1);
    localparam logic [4:0] IdxLast = 5'(NUM_ENTRIES - 1);

    state_e      st_q, st_d;
    logic [9:0]  div_q, div_d;
    logic [1:0]  ph_q, ph_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [4:0]  idx_q, idx_d;
    logic        nack_q, nack_d;
    logic        auto_q;
    logic        sclk_q, sclk_d;
    logic        sda_low_q, sda_low_d;
    logic        launch;
    logic        tick;
    logic        sda_in;
    logic [23:0] rom_entry;
    logic [7:0]  cur_byte;
    logic        tx_bit;

    camera_config_rom #(
        .REG_TABLE (REG_TABLE)
    ) u_rom (
        .index (idx_q),
        .entry (rom_entry)
    );

    assign camera_config_SDAT = sda_low_q ? 1'b0 : 1'bz;
    assign sda_in             = camera_config_SDAT;
    assign camera_config_SCLK = sclk_q;
    assign tick               = (div_q == DivLast);

    always_comb begin
        st_d   = st_q;
        div_d  = div_q;
        ph_d   = ph_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        idx_d  = idx_q;
        nack_d = nack_q;
        launch = 1'b0;

        if (st_q != StIdle && st_q != StFinish) begin
            div_d = tick ? 10'd0 : div_q + 10'd1;
            if (tick) begin
                ph_d = ph_q + 2'd1;
            end
        end

        unique case (st_q)
            StIdle: begin
                if (start || auto_q) begin
                    st_d   = StStart;
                    launch = 1'b1;
                    div_d  = '0;
                    ph_d   = '0;
                    bit_d  = '0;
                    byte_d = '0;
                    idx_d  = '0;
                    nack_d = 1'b0;
                end
            end
            StStart: begin
                if (tick && ph_q == 2'd3) begin
                    st_d = StSendBit;
                end
            end
            StSendBit: begin
                if (tick && ph_q == 2'd3) begin
                    if (bit_q == 3'd7) begin
                        st_d  = StAck;
                        bit_d = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StAck: begin
                // Sampled on the edge that opens Q3, i.e. mid-way through SCLK high.
                if (tick && ph_q == 2'd2) begin
                    nack_d = sda_in;
                end
                if (tick && ph_q == 2'd3) begin
                    if (nack_q || byte_q == 2'd3) begin
                        st_d = StStop;
                    end else begin
                        st_d   = StSendBit;
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            StStop: begin
                if (tick && ph_q == 2'd1) begin
                    ph_d = '0;
                    if (!nack_q && idx_q != IdxLast) begin
                        st_d   = StGap;
                        idx_d  = idx_q + 5'd1;
                        byte_d = '0;
                    end else begin
                        st_d = StFinish;
                    end
                end
            end
            StGap: begin
                if (tick && ph_q == 2'd3) begin
                    st_d = StStart;
                end
            end
            StFinish: st_d = StIdle;
            default:  st_d = StIdle;
        endcase
    end

    // Line levels are derived from the next state so they change on the same edge as the FSM.
    always_comb begin
        unique case (byte_d)
            2'd0: cur_byte = DEV_ADDR;
            2'd1: cur_byte = rom_entry[23:16];
            2'd2: cur_byte = rom_entry[15:8];
            2'd3: cur_byte = rom_entry[7:0];
        endcase
        tx_bit    = cur_byte[3'd7 - bit_d];
        sclk_d    = 1'b1;
        sda_low_d = 1'b0;
        case (st_d)
            StStart: sda_low_d = ph_d[1];
            StSendBit: begin
                sclk_d    = ph_d[1];
                sda_low_d = !tx_bit;
            end
            StAck: sclk_d = ph_d[1];
            StStop: begin
                sclk_d    = ph_d[0];
                sda_low_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            st_q      <= StIdle;
            div_q     <= '0;
            ph_q      <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            idx_q     <= '0;
            nack_q    <= 1'b0;
            auto_q    <= AUTO_START;
            sclk_q    <= 1'b1;
            sda_low_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            err_index <= '0;
        end else begin
            st_q      <= st_d;
            div_q     <= div_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            idx_q     <= idx_d;
            nack_q    <= nack_d;
            auto_q    <= auto_q & ~launch;
            sclk_q    <= sclk_d;
            sda_low_q <= sda_low_d;
            busy      <= (st_d != StIdle);
            if (launch) begin
                done      <= 1'b0;
                ack_error <= 1'b0;
            end
            if (st_q == StFinish) begin
                if (nack_q) begin
                    ack_error <= 1'b1;
                    err_index <= idx_q;
                end else begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/camera_config_seq.md
CAMERA_CONFIG_SEQ -- requirements
Module: camera_config_seq

Interface
REQ-001 Parameter CLK_DIV, default 125, clk_clk cycles per quarter SCLK period (50 MHz -> 100 kHz); legal range 2..1023.
REQ-002 Parameter AUTO_START, default 1, launches the sequence on the first cycle after reset release.
REQ-003 Parameter DEV_ADDR, default 8'hBA, I2C write address of the camera.
REQ-004 clk_clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset_reset_n  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  single-cycle pulse that requests a full table run.
REQ-007 camera_config_SCLK  output  1  I2C clock; driven low or released high.
REQ-008 camera_config_SDAT  inout  1  I2C data; open-drain: drives 0 or Z, never drives 1.
REQ-009 busy  output  1  high while a table run is in progress.
REQ-010 done  output  1  sticky flag: last run completed with every byte ACKed.
REQ-011 ack_error  output  1  sticky flag: last run aborted on a NACK.
REQ-012 err_index  output  5  table index of the entry that NACKed.

Function
REQ-013 The block writes NUM_REGS entries, indices 0..NUM_REGS-1, in ascending order; each entry is {reg_addr[7:0], data[15:0]}.
REQ-014 Each entry is sent as one transaction, in this order:
- START
- DEV_ADDR
- ACK
- reg_addr
- ACK
- data[15:8]
- ACK
- data[7:0]
- ACK
- STOP
REQ-015 Bytes are sent MSB first.
REQ-016 Every bit lasts 4 quarter phases of CLK_DIV cycles each.
- Q0 and Q1: SCLK low; SDAT updates at the start of Q0.
- Q2 and Q3: SCLK high.
REQ-017 ACK bit: SDAT is released during Q0..Q3 and sampled at the start of Q3; a high sample is a NACK.
REQ-018 START: SCLK and SDAT high for 2*CLK_DIV cycles, then SDAT low for 2*CLK_DIV cycles with SCLK high, then SCLK goes low.
REQ-019 STOP: SDAT low with SCLK low for CLK_DIV cycles, then SCLK high for CLK_DIV cycles, then SDAT released.
REQ-020 After each STOP there is an idle gap of 4*CLK_DIV cycles, with both lines released, before the next START.
REQ-021 FSM states: IDLE, START, SEND_BIT, ACK, STOP, GAP, FINISH.
- IDLE -> START on start, or on auto-start.
- START -> SEND_BIT.
- SEND_BIT -> ACK after 8 bits.
- ACK -> SEND_BIT while bytes remain; ACK -> STOP after the 4th byte or on NACK.
- STOP -> GAP if entries remain and there was no NACK, otherwise -> FINISH.
- GAP -> START.
- FINISH -> IDLE after 1 cycle.
REQ-022 On NACK:
- the remaining bits of that transaction are abandoned;
- STOP is issued;
- ack_error=1 and err_index=index are set in FINISH;
- done stays 0.
REQ-023 On a successful last entry, done=1 is set in FINISH.
REQ-024 busy=1 from the cycle after the launch through FINISH inclusive, and 0 in IDLE.
REQ-025 An accepted start clears done and ack_error in the same cycle; err_index holds its value until the next NACK.
REQ-026 start while busy=1 is ignored, including a start in the same cycle as the FINISH->IDLE transition.
REQ-027 The quarter-phase counter, bit counter (0..7), byte counter (0..3) and index counter wrap only under FSM control.
REQ-028 The index counter is 5 bits wide; NUM_REGS is at most 32.

Reset
REQ-029 While reset_reset_n=0 at a clock edge, the next state is:
- FSM in IDLE;
- SCLK released high and SDAT released Z;
- busy=0, done=0, ack_error=0, err_index=0;
- all counters 0.
REQ-030 Reset asserted mid-transaction aborts immediately, with no STOP generated.
REQ-031 With AUTO_START=1, the first START begins on the first cycle after reset_reset_n returns high.

Structure
REQ-032 Shared package camera_config_pkg contains:
- NUM_REGS;
- the entry type {reg_addr, data};
- the default register table constant for the D5M;
- DEV_ADDR default;
- the FSM state enum.
REQ-033 Sub-module camera_config_rom maps a 5-bit index to a 24-bit entry, combinationally from the package table.

Verification
REQ-034 Use CLK_DIV=2, a 3-entry table {0x01,0x0036}, {0x20,0xC000}, {0xA0,0x0001}, and a slave model that ACKs every byte.
- Release reset: SDAT falls while SCLK is high, then the bytes BA 01 00 36 appear, and so on.
- After the third STOP: done=1, busy=0, ack_error=0.
- Each bit is 8 cycles.
REQ-035 Slave NACKs the 2nd byte (0x20) of entry 1:
- STOP follows that ACK bit;
- entry 2 is never sent;
- ack_error=1, err_index=1, done=0, busy=0.
REQ-036 start pulse injected mid-entry 0 has no effect: the SCLK edge count and the entry count are unchanged.
REQ-037 Assert reset during bit 4 of entry 1 data[15:8]: the next cycle shows SCLK=1, SDAT=Z, busy=0; with AUTO_START=1 the sequence then restarts at entry 0.
REQ-038 AUTO_START=0:
- no bus activity for 1000 cycles after reset;
- a start pulse runs the table and gives done=1;
- a second start clears done in the same cycle and reruns identically.
